// File: rtl/risc16_prog_loader.sv
// -----------------------------------------------------------------------------
// risc16_prog_loader
//
// Writer side of the risc16 CPU/RAM interface. Receives a framed byte stream,
// assembles big-endian 16-bit instruction words and writes them into RAM from
// PROG_START upward. The CPU is held in reset until the whole image is loaded.
//
// Frame: SYNC_BYTE, LEN[15:8], LEN[7:0], then LEN words as HI,LO byte pairs.
//
// Ports
//   clk         in   1   system clock, all state changes on posedge
//   rst         in   1   synchronous, active-high reset
//   byte_in     in   8   stream data byte
//   byte_valid  in   1   byte_in holds a valid byte
//   byte_ready  out  1   loader accepts a byte this cycle (registered)
//   mem_addr    out  16  RAM address during a write
//   mem_in      out  16  RAM write data
//   rw          out  1   RAM write strobe (1 for exactly one cycle per word)
//   cpu_rst     out  1   hold CPU in reset (1) / release (0)
//   load_done   out  1   image loaded, CPU running (sticky until rst)
//   load_err    out  1   length rejected (sticky until rst)
// -----------------------------------------------------------------------------
module risc16_prog_loader #(
  parameter logic [15:0] PROG_START = 16'h000F,
  parameter logic [15:0] MAX_WORDS  = 16'd256,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_in,
  output logic        rw,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  // The highest address ever written must fit in 16 bits.
  if (32'(PROG_START) + 32'(MAX_WORDS) > 32'h0001_0000) begin : g_range_chk
    $error("risc16_prog_loader: PROG_START + MAX_WORDS - 1 exceeds 16'hFFFF");
  end

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  word_hi_q, word_hi_d;
  logic        ready_q, ready_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] len_full;
  logic [15:0] idx_inc;

  // ready_q already reflects the current state, so this is the handshake.
  assign accept   = byte_valid & ready_q;
  assign len_full = {count_q[15:8], byte_in};
  assign idx_inc  = idx_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    word_hi_d = word_hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = 1'b0;

    unique case (state_q)
      S_SYNC: begin
        if (accept && (byte_in == SYNC_BYTE)) begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          count_d = {byte_in, count_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if (len_full > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DAT_HI;
          end
        end
      end
      S_DAT_HI: begin
        if (accept) begin
          word_hi_d = byte_in;
          state_d   = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        // Write outputs are registered on entry to WRITE so that rw, mem_addr
        // and mem_in are all valid for exactly the WRITE cycle.
        if (accept) begin
          rw_d    = 1'b1;
          addr_d  = PROG_START + idx_q;
          data_d  = {word_hi_q, byte_in};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_SYNC;
    endcase

    // Status outputs are a registered decode of the next state.
    ready_d   = (state_d == S_SYNC)   || (state_d == S_LEN_HI) ||
                (state_d == S_LEN_LO) || (state_d == S_DAT_HI) ||
                (state_d == S_DAT_LO);
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SYNC;
      count_q   <= '0;
      idx_q     <= '0;
      word_hi_q <= '0;
      ready_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      word_hi_q <= word_hi_d;
      ready_q   <= ready_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign byte_ready = ready_q;
  assign rw         = rw_q;
  assign mem_addr   = addr_q;
  assign mem_in     = data_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule
